// File: rtl/fpa_arb_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
package fpa_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int W_DEF       = 32;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE,
    RESP      = ST_RESP
  } fpa_state_e;

endpackage

// File: rtl/fpa_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_pick
  import fpa_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_winner,
  output logic            o_any
);

  // Scan from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin : pick
    int c;
    c        = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      c = int'(i_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (i_req[c]) begin
        o_winner = IW'(c);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin scheduler sharing one FP adder (start/done handshake) between NREQ requesters.
// Optional watchdog on the adder handshake: define FPA_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | arbitrate; latch winner and its operands on any request
// LAUNCH    | one cycle: grant pulse and adder start
// WAIT_BUSY | wait for adder_done to drop
// WAIT_DONE | wait for adder_done to rise, then capture the sum
// RESP      | one cycle: response strobe to the granted requester
module fpa_arbiter
  import fpa_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] opa,
  input  logic [NREQ*W-1:0] opb,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_valid,
  output logic [W-1:0]    rsp_data,
  output logic            adder_start,
  output logic [W-1:0]    adder_a,
  output logic [W-1:0]    adder_b,
  input  logic            adder_done,
  input  logic [W-1:0]    adder_result,
  output logic            busy,
  output logic            err
);

  localparam int IW = $clog2(NREQ);

  fpa_state_e      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_rsp_data;
  logic [IW-1:0]   w_winner;
  logic            w_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [NREQ-1:0] w_idx_oh;
  logic            w_tmo;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IW'(i)) begin
        w_sel_a = opa[i*W +: W];
        w_sel_b = opb[i*W +: W];
      end
    end
  end

`ifdef FPA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmr;
  logic          r_err;

  // Fires only when the normal handshake edge has not arrived in the last allowed cycle.
  assign w_tmo = (r_tmr == '0) &&
                 (((r_state == WAIT_BUSY) && adder_done) ||
                  ((r_state == WAIT_DONE) && !adder_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == LAUNCH) || ((r_state == WAIT_BUSY) && !adder_done))
        r_tmr <= TW'(TIMEOUT - 1);
      else if (r_tmr != '0)
        r_tmr <= r_tmr - TW'(1);
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= IW'(NREQ - 1);
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx   <= w_winner;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: r_state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!adder_done) begin
            r_state <= WAIT_DONE;
          end else if (w_tmo) begin
            r_rsp_data <= W'(QNAN);
            r_ptr      <= r_idx;
            r_state    <= RESP;
          end
        end
        WAIT_DONE: begin
          if (adder_done) begin
            r_rsp_data <= adder_result;
            r_ptr      <= r_idx;
            r_state    <= RESP;
          end else if (w_tmo) begin
            r_rsp_data <= W'(QNAN);
            r_ptr      <= r_idx;
            r_state    <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_idx_oh    = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
  assign gnt         = (r_state == LAUNCH) ? w_idx_oh : '0;
  assign rsp_valid   = (r_state == RESP) ? w_idx_oh : '0;
  assign adder_start = (r_state == LAUNCH);
  assign busy        = (r_state != IDLE);
  assign adder_a     = r_a;
  assign adder_b     = r_b;
  assign rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_fpa_arbiter.sv
// Directed bench for fpa_arbiter with a behavioural start/done adder model.
// Build with FPA_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_fpa_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] opa, opb;
  logic [3:0]   gnt, rsp_valid;
  logic [31:0]  rsp_data, adder_a, adder_b, adder_result;
  logic         adder_start, adder_done, busy, err;

  int checks = 0;
  int errors = 0;

  // adder model controls: done stays high m_hi cycles after start, then low m_busy cycles
  int m_hi    = 0;
  int m_busy  = 3;
  bit m_stuck = 1'b0;
  int m_ph, m_cnt;

  always #5 clk = ~clk;

  fpa_arbiter #(.NREQ(4), .W(32), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .opa          (opa),
    .opb          (opb),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .adder_start  (adder_start),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .adder_done   (adder_done),
    .adder_result (adder_result),
    .busy         (busy),
    .err          (err)
  );

  // 1.0 + 2.0 is real IEEE; other pairs use an integer stand-in so sums are easy to hand-check
  function automatic logic [31:0] mock_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a + b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      adder_done   <= 1'b1;
      adder_result <= '0;
      m_ph         <= 0;
      m_cnt        <= 0;
    end else begin
      case (m_ph)
        0: if (adder_start) begin
             adder_result <= 32'hDEADBEEF;
             if (m_hi == 0) begin
               adder_done <= 1'b0; m_cnt <= m_busy - 1; m_ph <= 2;
             end else begin
               m_cnt <= m_hi - 1; m_ph <= 1;
             end
           end
        1: if (!m_stuck) begin
             if (m_cnt == 0) begin
               adder_done <= 1'b0; m_cnt <= m_busy - 1; m_ph <= 2;
             end else m_cnt <= m_cnt - 1;
           end
        2: if (m_cnt == 0) begin
             adder_done   <= 1'b1;
             adder_result <= mock_add(adder_a, adder_b);
             m_ph         <= 0;
           end else m_cnt <= m_cnt - 1;
        default: m_ph <= 0;
      endcase
    end
  end

  task automatic wait_gnt(input int bound, output logic [3:0] g);
    g = '0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (gnt != 0) begin g = gnt; return; end
    end
  endtask

  task automatic wait_rsp(input int bound, output logic [3:0] v, output int lat);
    v = '0; lat = 0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != 0) begin v = rsp_valid; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_strobes gnt %b rsp_valid %b want 0000 0000", gnt, rsp_valid); end
    checks++; if (adder_start !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ctrl start %b busy %b err %b want 0 0 0", adder_start, busy, err); end
    checks++; if (rsp_data !== 32'h0 || adder_a !== 32'h0 || adder_b !== 32'h0) begin errors++; $display("FAIL reset_data rsp %h a %h b %h want 0", rsp_data, adder_a, adder_b); end
  endtask

  task automatic test_single;
    logic [3:0] g, v; int lat;
    opa[64 +: 32] = 32'h3F800000; opb[64 +: 32] = 32'h40000000;
    m_hi = 0; m_busy = 3;
    req = 4'b0100;
    wait_gnt(10, g);
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", g); end
    checks++; if (adder_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", adder_start); end
    checks++; if (adder_a !== 32'h3F800000 || adder_b !== 32'h40000000) begin errors++; $display("FAIL single_operands a %h b %h want 3f800000 40000000", adder_a, adder_b); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0 || adder_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_pulse gnt %b start %b busy %b want 0000 0 1", gnt, adder_start, busy); end
    wait_rsp(20, v, lat);
    checks++; if (v !== 4'b0100) begin errors++; $display("FAIL single_rsp got %b want 0100", v); end
    checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL single_data got %h want 40400000", rsp_data); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency got %0d want 4 after the cycle following gnt", lat); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_data !== 32'h40400000) begin errors++; $display("FAIL single_after rsp %b busy %b data %h want 0000 0 40400000", rsp_valid, busy, rsp_data); end
  endtask

  task automatic test_all_four;
    logic [3:0] g, v, want; int lat;
    logic [31:0] exp_sum [4];
    exp_sum = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opa[i*32 +: 32] = 32'h10 * (i + 1);
      opb[i*32 +: 32] = i + 1;
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      want = 4'b0001 << i;
      wait_gnt(20, g);
      checks++; if (g !== want) begin errors++; $display("FAIL all4_gnt%0d got %b want %b", i, g, want); end
      req[i] = 1'b0;
      wait_rsp(20, v, lat);
      checks++; if (v !== want || rsp_data !== exp_sum[i] || busy !== 1'b1) begin errors++; $display("FAIL all4_rsp%0d rsp %b data %h busy %b want %b %h 1", i, v, rsp_data, busy, want, exp_sum[i]); end
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL all4_gap%0d rsp %b busy %b want 0000 0", i, rsp_valid, busy); end
    end
  endtask

  task automatic test_fairness;
    logic [3:0] g, v; int lat;
    logic [3:0]  want_g [3];
    logic [31:0] want_d [3];
    want_g = '{4'b1000, 4'b0010, 4'b1000};
    want_d = '{32'h44, 32'h205, 32'h44};
    opa[32 +: 32] = 32'h200; opb[32 +: 32] = 32'h5;
    req = 4'b0010;
    wait_gnt(20, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL fair_first got %b want 0010", g); end
    req = 4'b1010;
    wait_rsp(20, v, lat);
    checks++; if (v !== 4'b0010 || rsp_data !== 32'h205) begin errors++; $display("FAIL fair_first_rsp rsp %b data %h want 0010 205", v, rsp_data); end
    for (int j = 0; j < 3; j++) begin
      wait_gnt(20, g);
      checks++; if (g !== want_g[j]) begin errors++; $display("FAIL fair_gnt%0d got %b want %b", j, g, want_g[j]); end
      if (j == 2) req = 4'b0000;
      wait_rsp(20, v, lat);
      checks++; if (v !== want_g[j] || rsp_data !== want_d[j]) begin errors++; $display("FAIL fair_rsp%0d rsp %b data %h want %b %h", j, v, rsp_data, want_g[j], want_d[j]); end
    end
  endtask

  task automatic test_done_handshake;
    logic [3:0] g, v; int lat; int bad;
    m_hi = 5; m_busy = 2;
    opa[0 +: 32] = 32'h100; opb[0 +: 32] = 32'h23;
    req = 4'b0001;
    wait_gnt(20, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL hs_gnt got %b want 0001", g); end
    req = 4'b0000;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hs_wait_busy early-response cycles %0d want 0", bad); end
    wait_rsp(20, v, lat);
    checks++; if (v !== 4'b0001 || rsp_data !== 32'h123 || lat !== 4) begin errors++; $display("FAIL hs_rsp rsp %b data %h lat %0d want 0001 123 4", v, rsp_data, lat); end
    m_hi = 0; m_busy = 3;
  endtask

  task automatic test_reset_mid;
    logic [3:0] g, v; int lat; int bad;
    opa[96 +: 32] = 32'h300; opb[96 +: 32] = 32'h1;
    req = 4'b1000;
    wait_gnt(20, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL rmid_gnt got %b want 1000", g); end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0 || gnt !== 4'b0) begin errors++; $display("FAIL rmid_async busy %b rsp %b gnt %b want 0 0000 0000", busy, rsp_valid, gnt); end
    checks++; if (rsp_data !== 32'h0 || adder_a !== 32'h0) begin errors++; $display("FAIL rmid_data rsp %h a %h want 0 0", rsp_data, adder_a); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_discard stray cycles %0d want 0", bad); end
    req = 4'b1001;
    wait_gnt(20, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rmid_prio got %b want 0001", g); end
    req = 4'b0000;
    wait_rsp(20, v, lat);
    checks++; if (v !== 4'b0001 || rsp_data !== 32'h123) begin errors++; $display("FAIL rmid_rsp rsp %b data %h want 0001 123", v, rsp_data); end
  endtask

`ifdef FPA_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [3:0] g, v; int lat; int bad;
    m_stuck = 1'b1; m_hi = 1;
    req = 4'b0010;
    wait_gnt(20, g);
    checks++; if (g !== 4'b0010 || err !== 1'b0) begin errors++; $display("FAIL tmo_gnt gnt %b err %b want 0010 0", g, err); end
    req = 4'b0000;
    wait_rsp(30, v, lat);
    checks++; if (v !== 4'b0010 || rsp_data !== 32'h7FC00000) begin errors++; $display("FAIL tmo_rsp rsp %b data %h want 0010 7fc00000", v, rsp_data); end
    checks++; if (lat !== 9 || err !== 1'b1) begin errors++; $display("FAIL tmo_timing lat %0d err %b want 9 1", lat, err); end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (err !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_sticky bad cycles %0d want 0", bad); end
    m_stuck = 1'b0; m_hi = 0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear err %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask
`else
  task automatic test_err_tied;
    logic [3:0] g, v; int lat;
    req = 4'b0010;
    wait_gnt(20, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL err_tied_gnt got %b want 0010", g); end
    req = 4'b0000;
    wait_rsp(20, v, lat);
    checks++; if (v !== 4'b0010 || rsp_data !== 32'h205 || err !== 1'b0) begin errors++; $display("FAIL err_tied_rsp rsp %b data %h err %b want 0010 205 0", v, rsp_data, err); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_all_four;
    test_fairness;
    test_done_handshake;
    test_reset_mid;
`ifdef FPA_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_err_tied;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/fpa_arbiter.md
Name: fpa_arbiter

Overview:
- Round-robin scheduler that shares one floating-point adder (start/done handshake, single-precision operands) between NREQ requesters.
- Sits between requester blocks and the adder datapath/controller pair.
- Latches the winning operands, pulses the adder's start, and tracks the done handshake (high → low → high).
- Returns the sum to the granted requester with a one-cycle response strobe.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width.
- TIMEOUT, 64, watchdog limit in cycles per WAIT phase (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level.
- opa  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- opb  in  NREQ*W  operand B, same packing.
- gnt  out  NREQ  one-hot grant pulse.
- rsp_valid  out  NREQ  one-hot response strobe.
- rsp_data  out  W  result, valid when any rsp_valid bit is set.
- adder_start  out  1  start pulse to the adder.
- adder_a  out  W  latched operand A.
- adder_b  out  W  latched operand B.
- adder_done  in  1  adder done (high while adder idle).
- adder_result  in  W  adder sum.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog error (optional feature; tied 0 otherwise).

Behaviour:
- Reset values:
  - State IDLE, ptr = NREQ-1, so requester 0 is first priority.
  - gnt, rsp_valid, rsp_data, adder_start, adder_a, adder_b, busy, err all 0.
- States and transitions:
  - IDLE: if any req bit is set, winner = first set bit searching ptr+1, ptr+2, … modulo NREQ. At the clock edge, latch idx=winner, adder_a=opa[winner], adder_b=opb[winner], then go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH (exactly 1 cycle): gnt[idx]=1, adder_start=1. Go to WAIT_BUSY.
  - WAIT_BUSY: stay while adder_done=1; go to WAIT_DONE when adder_done=0.
  - WAIT_DONE: stay while adder_done=0. When adder_done=1, capture rsp_data=adder_result, set ptr=idx, go to RESP.
  - RESP (exactly 1 cycle): rsp_valid[idx]=1. Go to IDLE.
- Output timing and stability:
  - All outputs are registered or decoded from the registered state only; no combinational path from req to gnt.
  - adder_a and adder_b stay stable from LAUNCH until the next IDLE exit.
  - rsp_data holds its value until the next capture.
- Requester contract:
  - opa/opb must be stable while req[i]=1.
  - Each grant consumes exactly one operation.
  - A requester that keeps req high after gnt is re-arbitrated like any other requester, after the other pending requesters (round-robin).
- Minimum latency with an ideal adder: req visible in IDLE at cycle T → gnt at T+1 → rsp_valid at T+4 or later.
- Boundary conditions:
  - Simultaneous requests: round-robin only, no starvation; worst-case wait is NREQ-1 operations.
  - req changes outside IDLE: ignored.
  - adder_done already low on entry to WAIT_BUSY: advance next cycle.
  - rst asserted mid-operation: immediate return to reset values, in-flight result discarded, no rsp_valid. The adder shares the same rst.

Optional Feature:
- Macro FPA_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_BUSY and WAIT_DONE and clears on each state change.
  - On reaching TIMEOUT: set err (sticky until rst), go to RESP with rsp_data = 32'h7FC00000 (quiet NaN), and set ptr=idx.
- When undefined: no counter; the arbiter waits indefinitely; err is constant 0.

Decomposition:
- Package fpa_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP; 3 bits);
  - QNAN constant 32'h7FC00000;
  - default widths.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: req vector and ptr. Outputs: winner index and any_req.

Test Plan:
- Single request: req[2]=1, opa=32'h3F800000, opb=32'h40000000, behavioural adder with 3-cycle busy → gnt=4'b0100 for 1 cycle, adder_start pulse in the same cycle, rsp_valid=4'b0100 with rsp_data=32'h40400000 after done rises.
- All four requesting from reset, each dropping req after its gnt → grant order 0,1,2,3; exactly one rsp_valid per grant; busy low only between operations.
- Fairness: after requester 1 is served, req=4'b1010 held → grants 3 then 1, then 3 again; never 1 twice in a row.
- Done handshake: adder holds done high for 5 cycles after start → arbiter stays in WAIT_BUSY for 5 cycles; result is captured only on the later done rise.
- Reset mid-operation: assert rst in WAIT_DONE → no rsp_valid; busy=0; next request from requester 0 wins over requester 3.
- With FPA_ARB_TIMEOUT_EN, TIMEOUT=8, adder_done stuck high → after 8 cycles in WAIT_BUSY: err=1, rsp_valid[idx]=1, rsp_data=32'h7FC00000; err stays 1 until rst.
